// File: rtl/ram_arb_pkg.sv
// Shared widths, FSM encoding and port indices for the
// two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; remembers the last port
// granted so the other one wins the next tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any,
    output logic       pick
);

    logic last;

    always_comb begin
        any  = |req;
        pick = PORT_A;
        unique case (1'b1)
            (req == 2'b01): pick = PORT_A;
            (req == 2'b10): pick = PORT_B;
            (req == 2'b11): pick = (last == PORT_A) ? PORT_B : PORT_A;
            default:        pick = PORT_A;
        endcase
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= PORT_B;
        end else if (take && any) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serializes two request ports onto one synchronous RAM:
// IDLE picks a winner, ISSUE drives the RAM, CAPTURE returns read data.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_t state;
    state_t nstate;
    logic   take;
    logic   any;
    logic   pick;
    logic   owner;
    logic   lat_we;
    logic   issue;
    acc_t   sel;

    rr_arb2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  ({b_req, a_req}),
        .take (take),
        .any  (any),
        .pick (pick)
    );

    always_comb begin
        if (pick == PORT_B) begin
            sel = '{we: b_we, adr: b_adr, wdata: b_wdata};
        end else begin
            sel = '{we: a_we, adr: a_adr, wdata: a_wdata};
        end
    end

    always_comb begin
        nstate = state;
        take   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    take   = 1'b1;
                    nstate = ISSUE;
                end
            end
            ISSUE:   nstate = lat_we ? IDLE : CAPTURE;
            CAPTURE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // ram_adr/ram_din double as the latched address and data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= PORT_A;
            lat_we   <= 1'b0;
            ram_adr  <= '0;
            ram_din  <= '0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            state    <= nstate;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (take) begin
                owner   <= pick;
                lat_we  <= sel.we;
                ram_adr <= sel.adr;
                ram_din <= sel.wdata;
            end
            if (state == CAPTURE) begin
                if (owner == PORT_A) begin
                    a_rdata  <= ram_dout;
                    a_rvalid <= 1'b1;
                end else begin
                    b_rdata  <= ram_dout;
                    b_rvalid <= 1'b1;
                end
            end
        end
    end

    // Gated by rst so an access caught by reset never writes.
    assign issue = (state == ISSUE) && rst;
    assign a_gnt = issue && (owner == PORT_A);
    assign b_gnt = issue && (owner == PORT_B);
    assign ram_w = issue && lat_we;
    assign busy  = (state != IDLE) && rst;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: fixed vector table, corner-case sequences
// and random rounds against a transaction-level memory model.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ram_rst = 1'b1;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [2:0] a_adr = 0, b_adr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_w, busy;
    logic [2:0] ram_adr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] mem [8];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       ra;
        logic       awe;
        logic [2:0] aadr;
        logic [7:0] awd;
        logic       rb;
        logic       bwe;
        logic [2:0] badr;
        logic [7:0] bwd;
        logic       first;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    logic [7:0] mem_m [8];
    logic       last_m;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_adr    (a_adr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_adr    (b_adr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_w    (ram_w),
        .ram_adr  (ram_adr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    // RAM model: synchronous read, one cycle latency.
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_w) mem[ram_adr] <= ram_din;
            ram_dout <= mem[ram_adr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] outs();
        return {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_w, busy,
                a_rdata, b_rdata, ram_adr, ram_din};
    endfunction

    // Transaction-level model: serve requests in round-robin order.
    task automatic model_round(inout vec_t v);
        logic p [2];
        int   n;
        n = 0;
        if (v.ra && v.rb) begin
            v.first = (last_m == 1'b0) ? 1'b1 : 1'b0;
            p[0] = v.first;
            p[1] = ~v.first;
            n = 2;
        end else begin
            v.first = v.ra ? 1'b0 : 1'b1;
            p[0] = v.first;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            if (p[k] == 1'b0) begin
                if (v.awe) mem_m[v.aadr] = v.awd;
                else v.ea = mem_m[v.aadr];
            end else begin
                if (v.bwe) mem_m[v.badr] = v.bwd;
                else v.eb = mem_m[v.badr];
            end
            last_m = p[k];
        end
    endtask

    task automatic run_round(input vec_t v, input string tag);
        int ga, gb, va, vb, fin;
        ga = 0; gb = 0; va = 0; vb = 0;
        if (v.ra && v.rb) begin
            if (v.first == 1'b0) begin
                ga = 1; gb = v.awe ? 3 : 4;
            end else begin
                gb = 1; ga = v.bwe ? 3 : 4;
            end
        end else if (v.ra) ga = 1;
        else gb = 1;
        if (v.ra && !v.awe) va = ga + 2;
        if (v.rb && !v.bwe) vb = gb + 2;
        fin = 0;
        if (v.ra) fin = ga + (v.awe ? 1 : 2);
        if (v.rb && gb + (v.bwe ? 1 : 2) > fin) fin = gb + (v.bwe ? 1 : 2);
        a_req = v.ra; a_we = v.awe; a_adr = v.aadr; a_wdata = v.awd;
        b_req = v.rb; b_we = v.bwe; b_adr = v.badr; b_wdata = v.bwd;
        for (int c = 1; c <= fin; c++) begin
            @(negedge clk);
            chk({tag, " a_gnt"}, a_gnt, c == ga);
            chk({tag, " b_gnt"}, b_gnt, c == gb);
            chk({tag, " a_rvalid"}, a_rvalid, c == va);
            chk({tag, " b_rvalid"}, b_rvalid, c == vb);
            if (c == va) chk({tag, " a_rdata"}, a_rdata, v.ea);
            if (c == vb) chk({tag, " b_rdata"}, b_rdata, v.eb);
            if (a_gnt) a_req = 1'b0;
            if (b_gnt) b_req = 1'b0;
        end
        chk({tag, " idle"}, busy, 1'b0);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        chk({tag, " reset outs"}, outs(), 33'd0);
        rst = 1'b1;
        last_m = 1'b1;
    endtask

    vec_t tbl [8];
    vec_t v;
    vec_t m;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        ra awe aadr awd    rb bwe badr bwd  first ea     eb
        tbl[0] = '{1, 1, 3'd2, 8'h11, 1, 1, 3'd3, 8'h22, 0, 8'h00, 8'h00};
        tbl[1] = '{1, 0, 3'd2, 8'h00, 1, 0, 3'd3, 8'h00, 0, 8'h11, 8'h22};
        tbl[2] = '{0, 0, 3'd0, 8'h00, 1, 1, 3'd7, 8'h99, 1, 8'h00, 8'h00};
        tbl[3] = '{1, 0, 3'd7, 8'h00, 0, 0, 3'd0, 8'h00, 0, 8'h99, 8'h00};
        tbl[4] = '{1, 1, 3'd0, 8'hAA, 0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
        tbl[5] = '{1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0, 8'hAA, 8'h00};
        tbl[6] = '{1, 1, 3'd4, 8'h3C, 1, 0, 3'd4, 8'h00, 1, 8'h00, 8'h00};
        tbl[7] = '{1, 0, 3'd4, 8'h00, 1, 1, 3'd4, 8'hC3, 1, 8'hC3, 8'h00};
        for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
        last_m = 1'b1;

        repeat (2) @(negedge clk);
        chk("initial reset outs", outs(), 33'd0);
        ram_rst = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            m = tbl[i];
            model_round(m);
            run_round(tbl[i], $sformatf("vec%0d", i));
        end

        // Both ports hold reads: grants must alternate A,B every 3 cycles.
        do_reset("rr");
        begin
            int n;
            n = 0;
            a_req = 1; a_we = 0; a_adr = 3'd2;
            b_req = 1; b_we = 0; b_adr = 3'd3;
            for (int c = 1; c <= 19; c++) begin
                @(negedge clk);
                chk("rr gnt overlap", a_gnt & b_gnt, 1'b0);
                chk("rr rvalid overlap", a_rvalid & b_rvalid, 1'b0);
                if (a_rvalid) chk("rr a_rdata", a_rdata, mem_m[2]);
                if (b_rvalid) chk("rr b_rdata", b_rdata, mem_m[3]);
                if (a_gnt || b_gnt) begin
                    chk("rr order", b_gnt, n % 2);
                    chk("rr spacing", c, 1 + 3 * n);
                    n++;
                    if (n == 6) begin
                        a_req = 0;
                        b_req = 0;
                    end
                end
            end
            chk("rr grant count", n, 6);
            a_req = 0;
            b_req = 0;
            last_m = 1'b1;
        end

        // Reset during ISSUE of an A read aborts it.
        do_reset("abort pre");
        a_req = 1; a_we = 0; a_adr = 3'd7;
        @(negedge clk);
        chk("abort a_gnt", a_gnt, 1'b1);
        rst = 1'b0;
        a_req = 0;
        @(negedge clk);
        chk("abort outs", outs(), 33'd0);
        rst = 1'b1;
        last_m = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort no rvalid", a_rvalid, 1'b0);
        end
        v = '{1, 0, 3'd7, 8'h00, 0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
        model_round(v);
        run_round(v, "after abort");

        // Reset while idle keeps RAM contents.
        v = '{1, 1, 3'd5, 8'h5A, 0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
        model_round(v);
        run_round(v, "keep wr");
        do_reset("keep");
        v = '{1, 0, 3'd5, 8'h00, 0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
        model_round(v);
        chk("keep model", v.ea, 8'h5A);
        run_round(v, "keep rd");

        for (int r = 0; r < 40; r++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            v.ra = rq[0];
            v.rb = rq[1];
            v.awe = 1'($urandom);
            v.bwe = 1'($urandom);
            v.aadr = 3'($urandom);
            v.badr = 3'($urandom);
            v.awd = 8'($urandom);
            v.bwd = 8'($urandom);
            v.ea = 8'h00;
            v.eb = 8'h00;
            model_round(v);
            run_round(v, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
